// File: rtl/pipe_skid_stage_pkg.sv
// Shared stage bundles, reset payloads and occupancy state codes
// for the generic inter-stage pipeline register.
package pipe_skid_stage_pkg;

  localparam logic [31:0] PC_RESET = 32'h1C00_0000;
  localparam logic [31:0] INSN_NOP = 32'h0000_0013;

  typedef enum logic [4:0] {
    ALU_NOP = 5'd0,
    ALU_ADD = 5'd1,
    ALU_SUB = 5'd2,
    ALU_AND = 5'd3,
    ALU_OR  = 5'd4
  } aluop_e;

  typedef struct packed {
    logic ifetch;
    logic illegal;
    logic ecall;
    logic load;
    logic store;
  } exc_t;

  localparam exc_t EXCEPTION_NOP = '0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    exc_t        exc;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    aluop_e      aluop;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rd;
    exc_t        exc;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu_res;
    logic [31:0] st_data;
    logic [4:0]  rd;
    exc_t        exc;
  } ex_mem_bundle_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] wb_data;
    logic [4:0]  rd;
    logic        wen;
  } mem_wb_t;

  localparam int IF_ID_W  = $bits(if_id_t);
  localparam int ID_EX_W  = $bits(id_ex_t);
  localparam int EX_MEM_W = $bits(ex_mem_bundle_t);
  localparam int MEM_WB_W = $bits(mem_wb_t);

  localparam if_id_t IF_ID_RESET = '{
    pc: PC_RESET, instr: INSN_NOP, exc: EXCEPTION_NOP};
  localparam id_ex_t ID_EX_RESET = '{
    pc: PC_RESET, aluop: ALU_NOP, rs1_val: '0,
    rs2_val: '0, rd: '0, exc: EXCEPTION_NOP};
  localparam ex_mem_bundle_t EX_MEM_RESET = '{
    pc: PC_RESET, alu_res: '0, st_data: '0,
    rd: '0, exc: EXCEPTION_NOP};
  localparam mem_wb_t MEM_WB_RESET = '{
    pc: PC_RESET, wb_data: '0, rd: '0, wen: 1'b0};

  // Encoding doubles as the occupancy count.
  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_FULL    = 2'd1;
  localparam logic [1:0] ST_SKIDDED = 2'd2;

endpackage

// File: rtl/pipe_stage_ctrl.sv
// Occupancy FSM for the pipeline register: decides which
// datapath register loads and drives the handshake outputs.
module pipe_stage_ctrl
  import pipe_skid_stage_pkg::*;
#(
  parameter bit SKID = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       in_valid,
  input  logic       out_ready,
  output logic       in_ready,
  output logic       out_valid,
  output logic       load_main,
  output logic       load_skid,
  output logic       main_from_skid,
  output logic [1:0] occupancy
);

  logic [1:0] state_q, state_d;
  logic       in_acc, out_acc;

  assign out_valid = (state_q != ST_EMPTY);
  assign occupancy = state_q;
  assign in_acc    = in_valid & in_ready;
  assign out_acc   = out_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (in_acc) begin
          state_d   = ST_FULL;
          load_main = 1'b1;
        end
      end
      ST_FULL: begin
        if (in_acc && out_acc) begin
          load_main = 1'b1;
        end else if (in_acc) begin
          state_d   = ST_SKIDDED;
          load_skid = 1'b1;
        end else if (out_acc) begin
          state_d = ST_EMPTY;
        end
      end
      ST_SKIDDED: begin
        if (out_acc) begin
          state_d        = ST_FULL;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush shares reset's next state; handshakes this cycle are void.
    if (rst || flush) begin
      state_d        = ST_EMPTY;
      load_main      = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  if (SKID) begin : g_reg_ready
    logic in_ready_q, in_ready_d;
    assign in_ready_d = (state_d != ST_SKIDDED);
    assign in_ready   = in_ready_q;
    always_ff @(posedge clk) begin
      if (rst) in_ready_q <= 1'b1;
      else     in_ready_q <= in_ready_d;
    end
  end else begin : g_comb_ready
    assign in_ready = !out_valid || out_ready;
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Generic valid/ready pipeline register with optional two-entry
// skid buffer; payload is opaque and never interpreted.
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int              DATA_W    = 128,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter bit              SKID      = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic              load_main, load_skid, main_from_skid;
  logic              kill;
  logic [DATA_W-1:0] main_q, main_d, skid_q;

  assign kill = rst | flush;

  pipe_stage_ctrl #(.SKID(SKID)) u_ctrl (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .in_valid      (in_valid),
    .out_ready     (out_ready),
    .in_ready      (in_ready),
    .out_valid     (out_valid),
    .load_main     (load_main),
    .load_skid     (load_skid),
    .main_from_skid(main_from_skid),
    .occupancy     (occupancy)
  );

  always_comb begin
    main_d = main_q;
    if (kill)                main_d = RESET_VAL;
    else if (main_from_skid) main_d = skid_q;
    else if (load_main)      main_d = in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) main_q <= RESET_VAL;
    else     main_q <= main_d;
  end

  if (SKID) begin : g_skid
    logic [DATA_W-1:0] skid_d;
    always_comb begin
      skid_d = skid_q;
      if (kill)           skid_d = RESET_VAL;
      else if (load_skid) skid_d = in_data;
    end
    always_ff @(posedge clk) begin
      if (rst) skid_q <= RESET_VAL;
      else     skid_q <= skid_d;
    end
  end else begin : g_noskid
    logic unused_load_skid;
    assign unused_load_skid = load_skid;
    assign skid_q = RESET_VAL;
  end

  assign out_data = main_q;

  a_stall_stable: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready && !flush) |=>
      (out_valid && $stable(out_data)));
  a_full_not_ready: assert property (@(posedge clk) disable iff (rst)
    (occupancy == 2'd2) |-> !in_ready);
  a_valid_occ: assert property (@(posedge clk) disable iff (rst)
    out_valid == (occupancy != 2'd0));

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed vector table plus randomised scoreboard run for
// pipe_skid_stage with SKID=1 and SKID=0 instances.
module tb_pipe_skid_stage;

  localparam logic [7:0] RV = 8'hE5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1, fl1, iv1, ir1, ov1, or1;
  logic [7:0] d1, od1;
  logic [1:0] oc1;
  logic       rst0, fl0, iv0, ir0, ov0, or0;
  logic [7:0] d0, od0;
  logic [1:0] oc0;

  pipe_skid_stage #(.DATA_W(8), .RESET_VAL(RV), .SKID(1'b1)) u_s1 (
    .clk(clk), .rst(rst1), .flush(fl1),
    .in_valid(iv1), .in_ready(ir1), .in_data(d1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1),
    .occupancy(oc1));

  pipe_skid_stage #(.DATA_W(8), .RESET_VAL(RV), .SKID(1'b0)) u_s0 (
    .clk(clk), .rst(rst0), .flush(fl0),
    .in_valid(iv0), .in_ready(ir0), .in_data(d0),
    .out_valid(ov0), .out_ready(or0), .out_data(od0),
    .occupancy(oc0));

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ctl = {rst, flush, in_valid, out_ready}; ex = {out_valid, occ, in_ready}
  typedef struct {
    logic [3:0] ctl;
    logic [7:0] d;
    logic [3:0] ex;
    logic [7:0] od;
  } vec_t;

  function automatic vec_t v(logic [3:0] c, logic [7:0] dd,
                             logic [3:0] e, logic [7:0] o);
    vec_t r;
    r.ctl = c; r.d = dd; r.ex = e; r.od = o;
    return r;
  endfunction

  vec_t vt[23];
  logic [7:0] q1[$];
  logic [7:0] q0[$];

  initial begin
    logic [7:0] e;
    logic       rsave;

    vt[0]  = v(4'b1000, 8'h00, 4'b0001, RV);
    vt[1]  = v(4'b1000, 8'h00, 4'b0001, RV);
    vt[2]  = v(4'b0011, 8'h01, 4'b1011, 8'h01);
    vt[3]  = v(4'b0011, 8'h02, 4'b1011, 8'h02);
    vt[4]  = v(4'b0011, 8'h03, 4'b1011, 8'h03);
    vt[5]  = v(4'b0001, 8'h00, 4'b0001, 8'h03);
    vt[6]  = v(4'b0000, 8'h00, 4'b0001, 8'h03);
    vt[7]  = v(4'b0001, 8'h00, 4'b0001, 8'h03);
    vt[8]  = v(4'b0010, 8'h0A, 4'b1011, 8'h0A);
    vt[9]  = v(4'b0010, 8'h0B, 4'b1100, 8'h0A);
    vt[10] = v(4'b0010, 8'h0C, 4'b1100, 8'h0A);
    vt[11] = v(4'b0011, 8'h0C, 4'b1011, 8'h0B);
    vt[12] = v(4'b0011, 8'h0C, 4'b1011, 8'h0C);
    vt[13] = v(4'b0001, 8'h00, 4'b0001, 8'h0C);
    vt[14] = v(4'b0010, 8'h0A, 4'b1011, 8'h0A);
    vt[15] = v(4'b0010, 8'h0B, 4'b1100, 8'h0A);
    vt[16] = v(4'b0111, 8'h0D, 4'b0001, RV);
    vt[17] = v(4'b0010, 8'h0A, 4'b1011, 8'h0A);
    vt[18] = v(4'b1110, 8'h55, 4'b0001, RV);
    vt[19] = v(4'b0001, 8'h00, 4'b0001, RV);
    vt[20] = v(4'b0010, 8'h11, 4'b1011, 8'h11);
    vt[21] = v(4'b0110, 8'h22, 4'b0001, RV);
    vt[22] = v(4'b0000, 8'h00, 4'b0001, RV);

    rst1 = 1'b1; fl1 = 1'b0; iv1 = 1'b0; or1 = 1'b0; d1 = '0;
    rst0 = 1'b1; fl0 = 1'b0; iv0 = 1'b0; or0 = 1'b0; d0 = '0;

    for (int i = 0; i < 23; i++) begin
      {rst1, fl1, iv1, or1} = vt[i].ctl;
      d1 = vt[i].d;
      tick();
      chk($sformatf("v%0d_out_valid", i), 32'(ov1), 32'(vt[i].ex[3]));
      chk($sformatf("v%0d_occ", i), 32'(oc1), 32'(vt[i].ex[2:1]));
      chk($sformatf("v%0d_in_ready", i), 32'(ir1), 32'(vt[i].ex[0]));
      chk($sformatf("v%0d_out_data", i), 32'(od1), 32'(vt[i].od));
    end

    // SKID=0: combinational back-pressure and single-register loading
    tick();
    rst0 = 1'b0; iv0 = 1'b1; d0 = 8'h05; or0 = 1'b0;
    tick();
    chk("s0_load_valid", 32'(ov0), 32'd1);
    chk("s0_load_data", 32'(od0), 32'h05);
    chk("s0_stall_ready", 32'(ir0), 32'd0);
    d0 = 8'h06;
    tick();
    chk("s0_stall_hold", 32'(od0), 32'h05);
    chk("s0_stall_occ", 32'(oc0), 32'd1);
    or0 = 1'b1; d0 = 8'h07;
    #1;
    chk("s0_comb_ready", 32'(ir0), 32'd1);
    tick();
    chk("s0_pass_data", 32'(od0), 32'h07);
    chk("s0_pass_valid", 32'(ov0), 32'd1);
    iv0 = 1'b0;
    tick();
    chk("s0_drain_valid", 32'(ov0), 32'd0);
    chk("s0_drain_occ", 32'(oc0), 32'd0);

    // Randomised handshakes against queue scoreboards
    {rst1, fl1, iv1, or1} = 4'b1000;
    {rst0, fl0, iv0, or0} = 4'b1000;
    tick();
    rst1 = 1'b0; rst0 = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      iv1 = ($urandom_range(9) < 7);
      or1 = ($urandom_range(9) < 6);
      d1  = 8'($urandom);
      iv0 = ($urandom_range(9) < 7);
      or0 = ($urandom_range(9) < 6);
      d0  = 8'($urandom);
      #1;
      rsave = ir1;
      or1 = ~or1;
      #1;
      chk("s1_ready_indep", 32'(ir1), 32'(rsave));
      or1 = ~or1;
      #1;
      if (ov1 && or1) begin
        if (q1.size() == 0) chk("s1_spurious_out", 32'd1, 32'd0);
        else begin
          e = q1.pop_front();
          chk("s1_order", 32'(od1), 32'(e));
        end
      end
      if (iv1 && ir1) q1.push_back(d1);
      if (ov0 && or0) begin
        if (q0.size() == 0) chk("s0_spurious_out", 32'd1, 32'd0);
        else begin
          e = q0.pop_front();
          chk("s0_order", 32'(od0), 32'(e));
        end
      end
      if (iv0 && ir0) q0.push_back(d0);
    end
    @(posedge clk);
    #1;
    chk("s1_residual", 32'(oc1), 32'(q1.size()));
    chk("s0_residual", 32'(oc0), 32'(q0.size()));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Generic, parametrised inter-stage pipeline register for the back end. It replaces the hand-written per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque payload bus with a valid/ready handshake instead of a global pause vector, plus a synchronous flush used on exception or branch redirect.
- Optional 2-entry skid buffer registers in_ready, which breaks the long combinational stall path between stages.

Parameters:
- DATA_W, 128, payload width in bits (packed stage bundle).
- RESET_VAL, {DATA_W{1'b0}}, payload value loaded on reset/flush (e.g. NOP aluop, pc 0x1C000000).
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept a beat this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  downstream beat valid.
- out_ready  in  1  downstream accepts (low = stall).
- out_data  out  DATA_W  payload presented downstream.
- occupancy  out  2  number of held entries (0..2; max 1 when SKID=0).

Behaviour:
- Handshake rules:
  - Transfer occurs when valid && ready on the same rising edge.
  - out_valid and out_data are stable while out_valid && !out_ready.
  - Beats are never duplicated or reordered.
- Reset (rst=1, highest priority):
  - Held entries are cleared; main_data and skid_data load RESET_VAL.
  - Outputs: out_valid=0, occupancy=0, out_data=RESET_VAL.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-transfer drops the beat silently.
- Flush (rst=0, flush=1):
  - Same next-state as reset.
  - Any in/out handshake in the flush cycle is ignored: the input beat is not captured, and the output beat counts as consumed but invalidated.
  - in_ready may be 1 during flush; upstream must drop its beat itself.
- SKID=1 state machine (main = out register, skid = overflow register):
  - EMPTY (occ 0)
    - in_valid → FULL; main←in_data.
  - FULL (occ 1)
    - in accept && out accept → FULL; main←in_data.
    - in accept && !out accept → SKIDDED; skid←in_data.
    - !in && out accept → EMPTY.
    - otherwise hold.
  - SKIDDED (occ 2)
    - in_ready=0.
    - out accept → FULL; main←skid.
    - otherwise hold.
  - in_ready is a flop equal to (next state != SKIDDED). There is no combinational path from out_ready to in_ready.
  - Zero-bubble throughput: 1 beat/cycle with out_ready held high. Latency is 1 cycle from input accept to out_valid.
- SKID=0:
  - Single register.
  - in_ready = !out_valid || out_ready (combinational).
  - Load on in accept; clear valid on out accept without in accept.
- Payload is never interpreted. Data registers load only on accept, reset or flush.
- Boundary cases:
  - Simultaneous in/out accept in FULL keeps occupancy at 1.
  - out_ready toggled while EMPTY has no effect.
  - in_valid asserted while in_ready=0 is not captured.
  - occupancy never exceeds 2.
- Assertions:
  - out_data stable under stall.
  - occupancy==2 implies !in_ready.
  - out_valid==(occupancy!=0).

Decomposition:
- Shared package:
  - per-stage bundle typedefs (ex_mem_bundle_t etc.) and their widths, used as DATA_W;
  - stage RESET_VAL constants (ALU_NOP, EXCEPTION_NOP ×5, pc 0x1C000000).
- Sub-module pipe_stage_ctrl: the 3-state occupancy FSM producing load_main, load_skid, main_from_skid, in_ready and out_valid. The top holds only the datapath registers and the SKID generate.

Test Plan:
- Reset then streaming: rst 2 cycles; in_valid=1, in_data=0x01,0x02,0x03 on consecutive cycles, out_ready=1 → out_data 0x01,0x02,0x03 on cycles +1,+2,+3; in_ready stays 1.
- Stall with skid: FULL holding 0xA; out_ready=0; send 0xB → occupancy=2, in_ready=0 next cycle. 0xC is held on in_data and not taken. Release out_ready → 0xA, then 0xB, then 0xC accepted; no loss or duplication.
- Flush while SKIDDED: occupancy=2 with 0xA/0xB; flush=1 → next cycle out_valid=0, occupancy=0, out_data=RESET_VAL, in_ready=1.
- Reset over flush: rst=1 and flush=1 with in_valid=1, in_data=0x55 → state empty and 0x55 never appears.
- Randomised valid/ready for 10k cycles, SKID=1 and SKID=0, scoreboard → output sequence equals accepted input sequence. With SKID=1, no cycle has in_ready dependent on same-cycle out_ready.
- SKID=0 back-pressure: out_valid=1, out_ready=0 → in_ready=0 combinationally; out_ready=1 with in_valid=1, in_data=0x7 → out_data=0x7 next cycle.
